// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer keeps valid and its payload stable until that
// edge and never withdraws valid early. The consumer may change ready freely.
// in_*  : requester -> ALU (op, a, b qualified by in_valid).
// out_* : ALU -> consumer (q0, q1, st, err qualified by out_valid).
//
// Ports (signals):
//   in_valid, in_ready, op[7:0], a[WIDTH-1:0], b[WIDTH-1:0]
//   out_valid, out_ready, q0[WIDTH-1:0], q1[WIDTH-1:0], st[3:0], err
// Modports: master (requester/consumer side), slave (the ALU).
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q0;
    logic [WIDTH-1:0] q1;
    logic [3:0]       st;
    logic             err;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, q0, q1, st, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, q0, q1, st, err
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked sequential ALU. Accepts one operation at a time,
// computes single-cycle ops in EXEC, MUL (and optionally DIV) one bit per
// cycle, and holds the registered result until the consumer takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   bus        alu_seq_if.slave (in_valid/in_ready/op/a/b,
//              out_valid/out_ready/q0/q1/st/err)
//   dbg_state  current FSM state encoding (IDLE=0 EXEC=1 MUL=2 DIV=3 HOLD=4)
//
// st flags: bit 0 V, bit 1 C, bit 2 Z, bit 3 N.
// Optional feature: define ALU_SEQ_DIV_EN to build op 8'h12 as unsigned
// restoring DIV; otherwise op 8'h12 is treated as an invalid opcode.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_seq_if.slave   bus,
    output logic [2:0] dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_CPL  = 8'h03;
    localparam logic [7:0] OP_MUL  = 8'h04;
    localparam logic [7:0] OP_SHR  = 8'h05;
    localparam logic [7:0] OP_SHL  = 8'h06;
    localparam logic [7:0] OP_SAR  = 8'h07;
    localparam logic [7:0] OP_SAL  = 8'h08;
    localparam logic [7:0] OP_ROR  = 8'h09;
    localparam logic [7:0] OP_ROL  = 8'h0A;
    localparam logic [7:0] OP_NOT  = 8'h0B;
    localparam logic [7:0] OP_AND  = 8'h0C;
    localparam logic [7:0] OP_OR   = 8'h0D;
    localparam logic [7:0] OP_XOR  = 8'h0E;
    localparam logic [7:0] OP_NAND = 8'h0F;
    localparam logic [7:0] OP_NOR  = 8'h10;
    localparam logic [7:0] OP_XNOR = 8'h11;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [7:0] OP_DIV  = 8'h12;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_EXEC = 3'd1, ST_MUL = 3'd2, ST_DIV = 3'd3, ST_HOLD = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_EXEC = 3'd1, ST_MUL = 3'd2, ST_HOLD = 3'd4
    } state_t;
`endif

    state_t               state;
    logic [7:0]           op_r;
    logic [WIDTH-1:0]     a_r, b_r;
    logic [2*WIDTH-1:0]   acc_r;    // MUL: {partial high, multiplier}; DIV: {remainder, quotient}
    logic [SHW-1:0]       cnt_r;
    logic                 out_valid_r;
    logic [WIDTH-1:0]     q0_r, q1_r;
    logic [3:0]           st_r;
    logic                 err_r;

    assign bus.in_ready  = rst_n && (state == ST_IDLE);
    assign bus.out_valid = out_valid_r;
    assign bus.q0        = q0_r;
    assign bus.q1        = q1_r;
    assign bus.st        = st_r;
    assign bus.err       = err_r;
    assign dbg_state     = state;

    // ---------------- single-cycle datapath (from latched operands) -------
    logic [SHW-1:0]   sh, inv_sh, sh_m1;
    logic [WIDTH:0]   add_s, sub_d;
    logic [WIDTH-1:0] sub_x, sub_y, sal_out, sal_mask;
    logic [WIDTH-1:0] r_q0, r_q1;
    logic             f_v, f_c, f_n, flags_en, r_err;
    logic [3:0]       r_st;

    always_comb begin
        sh       = b_r[SHW-1:0];
        inv_sh   = '0 - sh;            // WIDTH - sh modulo WIDTH
        sh_m1    = sh - SHW'(1);
        sub_x    = (op_r == OP_CPL) ? '0 : a_r;
        sub_y    = (op_r == OP_CPL) ? a_r : b_r;
        add_s    = {1'b0, a_r} + {1'b0, b_r};
        sub_d    = {1'b0, sub_x} - {1'b0, sub_y};
        // Bits shifted out by a left shift, right-aligned (valid when sh != 0).
        sal_out  = a_r >> inv_sh;
        sal_mask = ~({WIDTH{1'b1}} << sh);
        r_q0     = '0;
        r_q1     = '0;
        f_v      = 1'b0;
        f_c      = 1'b0;
        f_n      = 1'b0;
        flags_en = 1'b1;
        r_err    = 1'b0;
        case (op_r)
            OP_NOP: begin
                r_q0     = a_r;
                r_q1     = b_r;
                flags_en = 1'b0;
            end
            OP_ADD: begin
                r_q0 = add_s[WIDTH-1:0];
                f_c  = add_s[WIDTH];
                f_v  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (add_s[WIDTH-1] != a_r[WIDTH-1]);
                f_n  = add_s[WIDTH-1];
            end
            OP_SUB, OP_CPL: begin
                r_q0 = sub_d[WIDTH-1:0];
                f_c  = sub_d[WIDTH];    // borrow == (x < y) unsigned
                f_v  = (sub_x[WIDTH-1] != sub_y[WIDTH-1]) && (sub_d[WIDTH-1] != sub_x[WIDTH-1]);
                f_n  = sub_d[WIDTH-1];
            end
            OP_SHR: begin
                r_q0 = a_r >> sh;
                f_c  = (sh != '0) && a_r[sh_m1];
                f_n  = r_q0[WIDTH-1];
            end
            OP_SAR: begin
                r_q0 = $unsigned($signed(a_r) >>> sh);
                f_c  = (sh != '0) && a_r[sh_m1];
                f_n  = r_q0[WIDTH-1];
            end
            OP_SHL, OP_SAL: begin
                r_q0 = a_r << sh;
                f_c  = (sh != '0) && a_r[inv_sh];
                f_n  = r_q0[WIDTH-1];
                if (op_r == OP_SAL)
                    f_v = (sh != '0) &&
                          ((sal_out & sal_mask) != (r_q0[WIDTH-1] ? sal_mask : '0));
            end
            OP_ROR: begin
                // sh == 0 gives (a >> 0) | (a << 0) == a.
                r_q0 = (a_r >> sh) | (a_r << inv_sh);
                f_c  = (sh != '0) && a_r[sh_m1];
                f_n  = r_q0[WIDTH-1];
            end
            OP_ROL: begin
                r_q0 = (a_r << sh) | (a_r >> inv_sh);
                f_c  = (sh != '0) && a_r[inv_sh];
                f_n  = r_q0[WIDTH-1];
            end
            OP_NOT:  r_q0 = ~a_r;
            OP_AND:  r_q0 = a_r & b_r;
            OP_OR:   r_q0 = a_r | b_r;
            OP_XOR:  r_q0 = a_r ^ b_r;
            OP_NAND: r_q0 = ~(a_r & b_r);
            OP_NOR:  r_q0 = ~(a_r | b_r);
            OP_XNOR: r_q0 = ~(a_r ^ b_r);
            default: begin
                r_err    = 1'b1;
                flags_en = 1'b0;
            end
        endcase
        r_st = flags_en ? {f_n, (r_q0 == '0), f_c, f_v} : 4'b0000;
    end

    // ---------------- iterative datapaths --------------------------------
    // Shift-add: add b into the high half when the current multiplier LSB is
    // set, then shift the whole accumulator right by one.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + (acc_r[0] ? {1'b0, b_r} : '0);
        mul_next = {mul_sum, acc_r[WIDTH-1:1]};
    end

`ifdef ALU_SEQ_DIV_EN
    // Restoring division: bring the next dividend bit into the remainder,
    // subtract b if it fits. With b == 0 every step "fits", which yields an
    // all-ones quotient and leaves the remainder equal to a.
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_t;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        div_sh   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        div_t    = {1'b0, div_sh} - {2'b00, b_r};
        div_ge   = !div_t[WIDTH+1];
        div_next = {(div_ge ? div_t[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                    acc_r[WIDTH-2:0], div_ge};
    end
`endif

    // ---------------- FSM with registered outputs -------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_r        <= '0;
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            q0_r        <= '0;
            q1_r        <= '0;
            st_r        <= '0;
            err_r       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        op_r  <= bus.op;
                        a_r   <= bus.a;
                        b_r   <= bus.b;
                        acc_r <= {{WIDTH{1'b0}}, bus.a};
                        cnt_r <= '0;
                        if (bus.op == OP_MUL)
                            state <= ST_MUL;
`ifdef ALU_SEQ_DIV_EN
                        else if (bus.op == OP_DIV)
                            state <= ST_DIV;
`endif
                        else
                            state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    q0_r        <= r_q0;
                    q1_r        <= r_q1;
                    st_r        <= r_st;
                    err_r       <= r_err;
                    out_valid_r <= 1'b1;
                    state       <= ST_HOLD;
                end
                ST_MUL: begin
                    acc_r <= mul_next;
                    cnt_r <= cnt_r + SHW'(1);
                    if (cnt_r == '1) begin
                        q0_r        <= mul_next[WIDTH-1:0];
                        q1_r        <= mul_next[2*WIDTH-1:WIDTH];
                        st_r        <= {1'b0, (mul_next == '0), 1'b0,
                                        |mul_next[2*WIDTH-1:WIDTH]};
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
`ifdef ALU_SEQ_DIV_EN
                ST_DIV: begin
                    acc_r <= div_next;
                    cnt_r <= cnt_r + SHW'(1);
                    if (cnt_r == '1) begin
                        q0_r        <= div_next[WIDTH-1:0];
                        q1_r        <= div_next[2*WIDTH-1:WIDTH];
                        st_r        <= (b_r == '0) ? 4'b0001
                                                   : {1'b0, (div_next == '0), 2'b00};
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                        state       <= ST_HOLD;
                    end
                end
`endif
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the 32-bit combinational `alu32_2x2`. It accepts one operation at a time over a valid/ready input port and returns a registered `{q0, q1, st}` result over a valid/ready output port. Logic ops take one cycle; MUL, and DIV when compiled in, run iteratively. It sits between the register-file read stage and writeback, and replaces the forced-output ALU with a clocked, stall-tolerant unit.

## Interface
- `WIDTH`, default 32: operand width; power of two, 8 to 64. `SHW = $clog2(WIDTH)`.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  unit can accept a request.
- `op`  in  8  opcode; encoding unchanged: 00 NOP, 01 ADD, 02 SUB, 03 CPL, 04 MUL, 05 SHR, 06 SHL, 07 SAR, 08 SAL, 09 ROR, 0A ROL, 0B NOT, 0C AND, 0D OR, 0E XOR, 0F NAND, 10 NOR, 11 XNOR, 12 DIV.
- `a`, `b`  in  WIDTH  operands.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer takes the result.
- `q0`, `q1`  out  WIDTH  primary result and secondary result (MUL high word, DIV remainder, NOP `b`; otherwise 0).
- `st`  out  4  flags: bit 0 V, bit 1 C, bit 2 Z, bit 3 N.
- `err`  out  1  the result belongs to an invalid opcode.

## Operation
- FSM states: IDLE, EXEC, MUL, DIV, HOLD.
- IDLE: `in_ready` is 1. On `in_valid`, latch `op`, `a` and `b`, then go to EXEC (single-cycle ops and invalid ops), MUL, or DIV.
- EXEC: compute the result, register it, go to HOLD.
- MUL: shift-add, one bit per cycle for WIDTH cycles, then HOLD.
- DIV: restoring division, one bit per cycle for WIDTH cycles, then HOLD.
- HOLD: `out_valid` is 1. `q0`, `q1`, `st` and `err` stay stable until `out_ready`, then return to IDLE.
- `in_ready` is 1 only in IDLE. At most one operation is in flight.
- Z means the whole result is zero: `q0` for single-word ops, `{q1, q0}` for MUL and DIV.
- ADD:
  - C is the carry out.
  - V is signed overflow: operands have equal signs and the result sign differs.
  - N is `q0[WIDTH-1]`.
- SUB:
  - `q0 = a - b`.
  - C is the borrow, i.e. `a < b` unsigned.
  - V is signed overflow.
  - N is `q0[WIDTH-1]`.
- CPL: `q0 = 0 - a`, with flags as for SUB with operands (0, a).
- MUL: unsigned. `q0` is the low word, `q1` the high word. V is `|q1`; C and N are 0.
- Shifts and rotates:
  - Shift amount is `b[SHW-1:0]`.
  - C is the last bit shifted or rotated out; C is 0 when the amount is 0.
  - N is `q0[WIDTH-1]`.
  - V is 0, except SAL, where V=1 if any shifted-out bit differs from the result sign.
  - SAR fills with `a[WIDTH-1]`. SHR and SHL fill with 0.
- Bitwise ops: only Z is meaningful; V, C and N are 0. NOT acts on `a`.
- NOP: `q0 = a`, `q1 = b`, `st = 0`.
- Invalid opcode: `q0 = q1 = 0`, `st = 0`, `err = 1`. `err` is 0 for every valid op.

## Timing
- Reset (`rst_n` low at a clock edge):
  - State goes to IDLE.
  - `out_valid`, `q0`, `q1`, `st` and `err` become 0.
  - `in_ready` is 0 while `rst_n` is low.
- Reset asserted mid-MUL, mid-DIV or during HOLD aborts the operation; no result is produced.
- Latency, from the accept edge to `out_valid` high:
  - single-cycle and invalid ops: 2 edges, i.e. EXEC then HOLD.
  - MUL and DIV: WIDTH+1 edges.
- With `out_ready` held high, `out_valid` is high for exactly one cycle.
- `in_ready` returns to 1 in the cycle after the output handshake. There is no input/output bypass.
- Sustained single-cycle throughput is one op per 3 cycles.
- `in_valid` while `in_ready` is 0 is ignored. The requester must hold `op`, `a` and `b` until accepted.
- Operands are sampled only at the accept edge; later changes have no effect.

## Configuration
- `ALU_SEQ_DIV_EN` defined:
  - Op 12 is unsigned DIV: `q0` is the quotient, `q1` the remainder.
  - Divide by zero: `q0` is all ones, `q1 = a`, V=1, C=0, N=0, Z=0.
  - Otherwise V=C=N=0.
- `ALU_SEQ_DIV_EN` undefined: the DIV state and datapath are absent, and op 12 behaves as an invalid opcode (`err=1`, 1-cycle path).

## Test plan
- WIDTH=32, ADD a=7FFFFFFF, b=1: `q0`=80000000, `st`=1001 (N, V). ADD a=FFFFFFFF, b=1: `q0`=0, `st`=0110 (Z, C). `out_valid` asserts on the 2nd edge after accept.
- MUL a=FFFFFFFF, b=2: `q0`=FFFFFFFE, `q1`=1, `st`=0001. `out_valid` asserts exactly 33 edges after accept, and `in_ready` stays 0 throughout.
- SHR a=00000003, b=1: `q0`=1, C=1. ROL a=80000001, b=4: `q0`=00000018, C=0. SAL a=40000000, b=1: `q0`=80000000, V=1. Shift with b=20 (amount 0): `q0`=a, C=0.
- Backpressure: hold `out_ready`=0 for 5 cycles after an AND result. `q0`, `st` and `out_valid` stay stable, `in_ready` stays 0, and a new `in_valid` is not taken until the cycle after `out_ready`.
- Reset asserted on cycle 10 of a MUL: `out_valid`=0, `q0`=0, `st`=0, and no result is produced. A following NOP a=5, b=9 returns `q0`=5, `q1`=9.
- Op 13 returns `err`=1, `q0`=0, `st`=0. With `ALU_SEQ_DIV_EN` defined, DIV 100/7 gives `q0`=14, `q1`=2, and DIV by 0 gives `q0`=FFFFFFFF, V=1. Without the macro, op 12 gives `err`=1.
